ro_result_streamer: RTL and testbench

- Sits directly downstream of the ring-oscillator frequency counter bank.
- On a sample request, freezes the counter bank's output through its pause input and captures the packed 32-bit counts into a shadow register.
- Serialises the captured counts as a byte frame over a valid/ready stream for the UART TX / host link.
- Single clock domain. The packed count bus must be stable while pause is held.

---
 rtl/ro_result_streamer_if.sv | 10 +
 rtl/ro_result_streamer.sv | 138 +++++++++++++
 tb/tb_ro_result_streamer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ro_result_streamer_if.sv
// Byte stream from ro_result_streamer to the UART TX / host link.
// Master drives data/valid, slave returns ready; a byte moves when valid && ready.
interface ro_result_streamer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ro_result_streamer.sv
// Freezes the RO counter bank, snapshots its counts and streams them as a byte frame.
// Optional trailing XOR checksum byte enabled by defining RO_STREAM_CSUM_EN.
module ro_result_streamer #(
    parameter int unsigned NUM_COUNTERS  = 1,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  HEADER_BYTE   = 8'hA5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_req,
    input  logic [NUM_COUNTERS*32-1:0]   freq_in,
    output logic                         ro_pause,
    output logic                         busy,
    output logic [7:0]                   overrun_cnt,
    ro_result_streamer_if.master         strm
);

`ifdef RO_STREAM_CSUM_EN
    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, HDR, CNT, IDX, DATA, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, HDR, CNT, IDX, DATA} state_t;
`endif

    localparam logic [7:0] LAST_IDX    = 8'(NUM_COUNTERS - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] NUM_BYTE    = 8'(NUM_COUNTERS);

    state_t                      state, state_n;
    logic [7:0]                  settle_cnt;
    logic [7:0]                  idx;
    logic [1:0]                  byte_sel;
    logic [NUM_COUNTERS*32-1:0]  shadow;
    logic [31:0]                 cur_word;
    logic [7:0]                  cur_byte;
    logic                        accept;
    logic                        last_cnt;
    logic                        valid_c;
    logic [7:0]                  data_c;
`ifdef RO_STREAM_CSUM_EN
    logic [7:0]                  csum;
`endif

    // Outputs decode only registered state, so out_ready never reaches out_data.
    assign strm.out_valid = valid_c;
    assign strm.out_data  = data_c;
    assign accept         = valid_c && strm.out_ready;
    assign ro_pause       = (state == SETTLE) || (state == CAPTURE);
    assign busy           = (state != IDLE);
    assign last_cnt       = (idx == LAST_IDX);

    assign cur_word = 32'(shadow >> {idx, 5'd0});
    assign cur_byte = 8'(cur_word >> {byte_sel, 3'd0});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        valid_c = 1'b0;
        data_c  = 8'h00;
        case (state)
            IDLE:    if (sample_req) state_n = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_n = CAPTURE;
            CAPTURE: state_n = HDR;
            HDR: begin
                valid_c = 1'b1;
                data_c  = HEADER_BYTE;
                if (accept) state_n = CNT;
            end
            CNT: begin
                valid_c = 1'b1;
                data_c  = NUM_BYTE;
                if (accept) state_n = IDX;
            end
            IDX: begin
                valid_c = 1'b1;
                data_c  = idx;
                if (accept) state_n = DATA;
            end
            DATA: begin
                valid_c = 1'b1;
                data_c  = cur_byte;
                if (accept && byte_sel == 2'd0) begin
`ifdef RO_STREAM_CSUM_EN
                    state_n = last_cnt ? CSUM : IDX;
`else
                    state_n = last_cnt ? IDLE : IDX;
`endif
                end
            end
`ifdef RO_STREAM_CSUM_EN
            CSUM: begin
                valid_c = 1'b1;
                data_c  = csum;
                if (accept) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt  <= 8'd0;
            idx         <= 8'd0;
            byte_sel    <= 2'd0;
            shadow      <= '0;
            overrun_cnt <= 8'd0;
        end else begin
            settle_cnt <= (state == SETTLE) ? settle_cnt + 8'd1 : 8'd0;

            if (state == CAPTURE) begin
                shadow <= freq_in;
                idx    <= 8'd0;
            end else if (state == DATA && accept && byte_sel == 2'd0 && !last_cnt) begin
                idx <= idx + 8'd1;
            end

            // Counts go out MSB first: byte_sel walks 3..0.
            if (state == IDX && accept)       byte_sel <= 2'd3;
            else if (state == DATA && accept) byte_sel <= byte_sel - 2'd1;

            if (sample_req && busy && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

`ifdef RO_STREAM_CSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               csum <= 8'h00;
        else if (state == CAPTURE)                  csum <= 8'h00;
        else if (accept && state != CSUM)           csum <= csum ^ data_c;
    end
`endif

endmodule

// File: tb/tb_ro_result_streamer.sv
// Self-checking bench: table vectors, random frames vs. a queue model, and corner sequences.
module tb_ro_result_streamer;
    localparam int NA = 2, SA = 4, NB = 1, SB = 1;
`ifdef RO_STREAM_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int FLEN_A = 2 + 5*NA + CS;
    localparam int FLEN_B = 2 + 5*NB + CS;

    logic clk = 0, reset_n = 0;
    logic req_a = 0, req_b = 0;
    logic [NA*32-1:0] freq_a = '0;
    logic [NB*32-1:0] freq_b = '0;
    logic pause_a, pause_b, busy_a, busy_b;
    logic [7:0] ovr_a, ovr_b;
    ro_result_streamer_if s_a();
    ro_result_streamer_if s_b();

    ro_result_streamer #(.NUM_COUNTERS(NA), .SETTLE_CYCLES(SA)) dut_a (
        .clk(clk), .reset_n(reset_n), .sample_req(req_a), .freq_in(freq_a),
        .ro_pause(pause_a), .busy(busy_a), .overrun_cnt(ovr_a), .strm(s_a.master));
    ro_result_streamer #(.NUM_COUNTERS(NB), .SETTLE_CYCLES(SB)) dut_b (
        .clk(clk), .reset_n(reset_n), .sample_req(req_b), .freq_in(freq_b),
        .ro_pause(pause_b), .busy(busy_b), .overrun_cnt(ovr_b), .strm(s_b.master));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    logic [7:0] got_q[$], exp_q[$];

    typedef struct { logic [31:0] c0, c1; bit stall; logic [95:0] exp; } vec_t;
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++; n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    function automatic void add_csum();
`ifdef RO_STREAM_CSUM_EN
        logic [7:0] x = 8'h00;
        foreach (exp_q[j]) x ^= exp_q[j];
        exp_q.push_back(x);
`endif
    endfunction

    // Frame model straight from the framing rules.
    function automatic void model(input int n, input logic [255:0] f);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'(i));
            for (int k = 3; k >= 0; k--) exp_q.push_back(f[i*32 + 8*k +: 8]);
        end
        add_csum();
    endfunction

    task automatic cmp_frame(input string nm);
        chk({nm, "_len"}, got_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            chk($sformatf("%s_b%0d", nm, j), got_q[j], exp_q[j]);
    endtask

    // Pulses sample_req on DUT A and collects one frame; mode 1 = capture isolation,
    // mode 2 = overrun pulses mid-frame and on the final accept cycle.
    task automatic run_a(input bit stall, input int mode, output int pause_n, output int lat);
        int cyc = 0;
        bit done = 0, prev_stall = 0, rdy;
        logic [7:0] prev_data = 0;
        got_q.delete(); pause_n = 0; lat = 0;
        @(negedge clk); req_a = 1;
        while (!done && cyc < 2000) begin
            @(negedge clk); cyc++; req_a = 0;
            if (pause_a) pause_n++;
            if (s_a.out_valid && lat == 0) lat = cyc;
            if (prev_stall) begin
                chk("stall_valid", s_a.out_valid, 1);
                chk("stall_data", s_a.out_data, prev_data);
            end
            if (mode == 1 && cyc == SA + 2) freq_a = '1;
            if (mode == 2 && (cyc == 6 || cyc == 9)) req_a = 1;
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s_a.out_ready = rdy;
            prev_stall = s_a.out_valid && !rdy;
            prev_data = s_a.out_data;
            if (s_a.out_valid && rdy) begin
                got_q.push_back(s_a.out_data);
                if (got_q.size() == FLEN_A) begin
                    done = 1;
                    if (mode == 2) req_a = 1;
                end
            end
        end
        if (!done) timeout("frame_a");
    endtask

    task automatic run_b(input string nm);
        int cyc = 0, pn = 0, lat = 0;
        got_q.delete();
        @(negedge clk); req_b = 1; s_b.out_ready = 1;
        while (got_q.size() < FLEN_B && cyc < 200) begin
            @(negedge clk); cyc++; req_b = 0;
            if (pause_b) pn++;
            if (s_b.out_valid && lat == 0) lat = cyc;
            if (s_b.out_valid) got_q.push_back(s_b.out_data);
        end
        if (got_q.size() < FLEN_B) timeout("frame_b");
        chk({nm, "_lat"}, lat, SB + 2);
        chk({nm, "_pause"}, pn, SB + 1);
        cmp_frame(nm);
    endtask

    initial begin
        int pn, lat, w;
        logic [63:0] f;
        vecs[0] = '{32'h1122_3344, 32'h0000_0102, 1'b0, 96'hA5_02_00_11_22_33_44_01_00_00_01_02};
        vecs[1] = '{32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 96'hA5_02_00_00_00_00_00_01_DE_AD_BE_EF};
        vecs[2] = '{32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 96'hA5_02_00_80_00_00_01_01_FF_FF_FF_FF};
        vecs[3] = '{32'hCAFE_F00D, 32'h0000_0000, 1'b0, 96'hA5_02_00_CA_FE_F0_0D_01_00_00_00_00};
        s_a.out_ready = 1; s_b.out_ready = 1;

        repeat (2) @(negedge clk);
        chk("rst_pause", pause_a, 0);
        chk("rst_valid", s_a.out_valid, 0);
        chk("rst_data", s_a.out_data, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ovr", ovr_a, 0);
        reset_n = 1;
        @(negedge clk);

        // Table vectors, issued back to back.
        foreach (vecs[v]) begin
            freq_a = {vecs[v].c1, vecs[v].c0};
            exp_q.delete();
            for (int k = 0; k < 12; k++) exp_q.push_back(vecs[v].exp[95 - 8*k -: 8]);
            add_csum();
            run_a(vecs[v].stall, 0, pn, lat);
            cmp_frame($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_pause", v), pn, SA + 1);
            chk($sformatf("vec%0d_lat", v), lat, SA + 2);
        end

        // Random counts with random backpressure.
        for (int r = 0; r < 12; r++) begin
            f = {$urandom, $urandom};
            freq_a = f;
            model(NA, 256'(f));
            run_a(1'($urandom_range(0, 1)), 0, pn, lat);
            cmp_frame($sformatf("rnd%0d", r));
        end

        // Capture isolation.
        f = 64'h0102_0304_A0B0_C0D0;
        freq_a = f;
        model(NA, 256'(f));
        run_a(1'b1, 1, pn, lat);
        cmp_frame("iso");
        freq_a = f;

        // Overrun: two mid-frame pulses plus one on the final accept cycle.
        model(NA, 256'(f));
        run_a(1'b0, 2, pn, lat);
        cmp_frame("ovr");
        @(negedge clk); req_a = 0;
        chk("ovr_cnt3", ovr_a, 3);
        w = 0;
        repeat (8) begin @(negedge clk); if (busy_a) w++; end
        chk("ovr_no_frame", w, 0);

        // Saturation while stalled in HDR.
        @(negedge clk); req_a = 1; s_a.out_ready = 0;
        repeat (300) @(negedge clk);
        req_a = 0;
        chk("ovr_sat", ovr_a, 255);
        chk("stall_hdr_valid", s_a.out_valid, 1);
        chk("stall_hdr_data", s_a.out_data, 8'hA5);
        s_a.out_ready = 1;
        w = 0;
        while (busy_a && w < 50) begin @(negedge clk); w++; end
        if (busy_a) timeout("drain");

        // Reset during DATA of counter 0.
        @(negedge clk); req_a = 1;
        @(negedge clk); req_a = 0;
        repeat (SA + 5) @(negedge clk);
        chk("pre_rst_valid", s_a.out_valid, 1);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_pause", pause_a, 0);
        chk("mid_rst_valid", s_a.out_valid, 0);
        chk("mid_rst_data", s_a.out_data, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_ovr", ovr_a, 0);
        @(negedge clk); reset_n = 1;
        model(NA, 256'(f));
        run_a(1'b0, 0, pn, lat);
        cmp_frame("post_rst");
        chk("post_rst_lat", lat, SA + 2);

        // Edge configuration N=1, SETTLE_CYCLES=1.
        freq_b = 32'h89AB_CDEF;
        exp_q = '{8'hA5, 8'h01, 8'h00, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        add_csum();
        run_b("edge");
        for (int r = 0; r < 3; r++) begin
            freq_b = $urandom;
            model(NB, 256'(freq_b));
            run_b($sformatf("edge_rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
